// File: rtl/wb_write_arbiter_if.sv
// Bus bundle for wb_write_arbiter: pipeline writeback request, auxiliary result
// handshake with FIFO status, and the registered register-file write port.
interface wb_write_arbiter_if #(
    parameter int FIFO_DEPTH = 2
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic             pipe_we;
    logic [4:0]       pipe_rd;
    logic [31:0]      pipe_wdata;
    logic             pipe_stall;

    logic             aux_valid;
    logic             aux_ready;
    logic [4:0]       aux_rd;
    logic [31:0]      aux_wdata;
    logic             aux_pending;
    logic [CNT_W-1:0] aux_count;

    logic             rf_we;
    logic [4:0]       rf_rd;
    logic [31:0]      rf_wdata;

    modport master (
        output pipe_we, pipe_rd, pipe_wdata, aux_valid, aux_rd, aux_wdata,
        input  pipe_stall, aux_ready, aux_pending, aux_count, rf_we, rf_rd, rf_wdata
    );

    modport slave (
        input  pipe_we, pipe_rd, pipe_wdata, aux_valid, aux_rd, aux_wdata,
        output pipe_stall, aux_ready, aux_pending, aux_count, rf_we, rf_rd, rf_wdata
    );
endinterface

// File: rtl/wb_write_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority over FIFO-buffered
// auxiliary results, with a starvation counter. Optional bypass: WB_WRITE_ARBITER_BYPASS_EN.
module wb_write_arbiter #(
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    wb_write_arbiter_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SC_W  = $clog2(STARVE_LIMIT + 1);

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] wdata;
    } entry_t;

    entry_t           mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [SC_W-1:0]  starve_cnt_q, starve_cnt_d;
    logic             rf_we_q, rf_we_d;
    logic [4:0]       rf_rd_q, rf_rd_d;
    logic [31:0]      rf_wdata_q, rf_wdata_d;

    logic   pending, full, ready, starve;
    logic   grant_pipe, grant_fifo, grant_byp, push;
    entry_t head, win;

    assign head = mem_q[rd_ptr_q];

    always_comb begin
        // NOTE: every signal gets a default first, so no branch can leave one unassigned and infer a latch.
        grant_pipe = 1'b0;
        grant_fifo = 1'b0;
        grant_byp  = 1'b0;
        win        = '0;
        pending    = (count_q != '0);
        full       = (count_q == CNT_W'(FIFO_DEPTH));
        ready      = !full && !reset;
        starve     = (starve_cnt_q >= SC_W'(STARVE_LIMIT)) && pending;

        if (starve) begin
            grant_fifo = 1'b1;
            win        = head;
        end else if (bus.pipe_we) begin
            grant_pipe = 1'b1;
            win        = {bus.pipe_rd, bus.pipe_wdata};
        end else if (pending) begin
            grant_fifo = 1'b1;
            win        = head;
        end
`ifdef WB_WRITE_ARBITER_BYPASS_EN
        else if (bus.aux_valid && ready) begin
            grant_byp = 1'b1;
            win       = {bus.aux_rd, bus.aux_wdata};
        end
`endif

        push = bus.aux_valid && ready && !grant_byp;

        // x0 writes are consumed like any other grant but never reach the register file
        rf_we_d    = (grant_pipe || grant_fifo || grant_byp) && (win.rd != 5'd0);
        rf_rd_d    = rf_we_d ? win.rd    : rf_rd_q;
        rf_wdata_d = rf_we_d ? win.wdata : rf_wdata_q;

        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(grant_fifo);
        count_d  = count_q + CNT_W'(push) - CNT_W'(grant_fifo);

        if (!pending || grant_fifo) begin
            starve_cnt_d = '0;
        end else if (grant_pipe && (starve_cnt_q < SC_W'(STARVE_LIMIT))) begin
            starve_cnt_d = starve_cnt_q + SC_W'(1);
        end else begin
            starve_cnt_d = starve_cnt_q;
        end
    end

    // NOTE: FIFO storage is not reset; the pointers and count alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {bus.aux_rd, bus.aux_wdata};
        end
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            starve_cnt_q <= '0;
            rf_we_q      <= 1'b0;
            rf_rd_q      <= '0;
            rf_wdata_q   <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            starve_cnt_q <= starve_cnt_d;
            rf_we_q      <= rf_we_d;
            rf_rd_q      <= rf_rd_d;
            rf_wdata_q   <= rf_wdata_d;
        end
    end

    assign bus.pipe_stall  = starve && bus.pipe_we;
    assign bus.aux_ready   = ready;
    assign bus.aux_pending = pending;
    assign bus.aux_count   = count_q;
    assign bus.rf_we       = rf_we_q;
    assign bus.rf_rd       = rf_rd_q;
    assign bus.rf_wdata    = rf_wdata_q;
endmodule

// File: tb/tb_wb_write_arbiter.sv
// Scoreboard bench for wb_write_arbiter: a queue-based reference model predicts each
// cycle's grant; a posedge monitor compares the registered rf_* write against it.
module tb_wb_write_arbiter;
    localparam int FIFO_DEPTH   = 2;
    localparam int STARVE_LIMIT = 4;
`ifdef WB_WRITE_ARBITER_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    typedef struct packed {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    wb_write_arbiter_if #(.FIFO_DEPTH(FIFO_DEPTH)) bus();

    wb_write_arbiter #(
        .FIFO_DEPTH  (FIFO_DEPTH),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Reference model state
    ent_t m_fifo[$];
    int   m_wins;
    exp_t exp_q[$];

    logic        cur_we;
    logic [4:0]  cur_rd;
    logic [31:0] cur_wd;
    logic        cur_av;
    logic [4:0]  cur_ard;
    logic [31:0] cur_awd;
    bit          last_stall;
    bit          last_aux_taken;
    bit          running;

    int n_tests;
    int n_fail;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; the model decides the grant from the arbitration rules.
    task automatic drive();
        bit   pend, rdy, starve, taken;
        int   src;
        ent_t w;
        exp_t e;
        @(negedge clk);
        reset          = 1'b0;
        bus.pipe_we    = cur_we;
        bus.pipe_rd    = cur_rd;
        bus.pipe_wdata = cur_wd;
        bus.aux_valid  = cur_av;
        bus.aux_rd     = cur_ard;
        bus.aux_wdata  = cur_awd;
        #1;
        pend   = (m_fifo.size() > 0);
        rdy    = (m_fifo.size() < FIFO_DEPTH);
        starve = pend && (m_wins >= STARVE_LIMIT);
        check("pipe_stall",  32'(bus.pipe_stall),  32'(starve && cur_we));
        check("aux_ready",   32'(bus.aux_ready),   32'(rdy));
        check("aux_pending", 32'(bus.aux_pending), 32'(pend));
        check("aux_count",   32'(bus.aux_count),   32'(m_fifo.size()));

        src = 0;
        w   = '0;
        if (starve) begin
            src = 2; w = m_fifo[0];
        end else if (cur_we) begin
            src = 1; w = ent_t'({cur_rd, cur_wd});
        end else if (pend) begin
            src = 2; w = m_fifo[0];
        end else if (BYP && cur_av) begin
            src = 3; w = ent_t'({cur_ard, cur_awd});
        end
        e.we   = (src != 0) && (w.rd != 5'd0);
        e.rd   = w.rd;
        e.data = w.data;
        exp_q.push_back(e);

        taken = cur_av && rdy;
        if (src == 2) void'(m_fifo.pop_front());
        if (taken && src != 3) m_fifo.push_back(ent_t'({cur_ard, cur_awd}));
        if (!pend || src == 2) m_wins = 0;
        else if (src == 1 && m_wins < STARVE_LIMIT) m_wins++;
        last_stall     = starve && cur_we;
        last_aux_taken = taken;
    endtask

    // Asynchronous reset in the middle of traffic; the next drive() releases it.
    task automatic reset_check();
        @(negedge clk);
        reset          = 1'b1;
        bus.pipe_we    = 1'b1;
        bus.aux_valid  = 1'b1;
        #1;
        check("rst_rf_we",       32'(bus.rf_we),       32'd0);
        check("rst_rf_rd",       32'(bus.rf_rd),       32'd0);
        check("rst_rf_wdata",    bus.rf_wdata,         32'd0);
        check("rst_pipe_stall",  32'(bus.pipe_stall),  32'd0);
        check("rst_aux_ready",   32'(bus.aux_ready),   32'd0);
        check("rst_aux_pending", 32'(bus.aux_pending), 32'd0);
        check("rst_aux_count",   32'(bus.aux_count),   32'd0);
        m_fifo.delete();
        exp_q.delete();
        m_wins         = 0;
        last_stall     = 1'b0;
        last_aux_taken = 1'b0;
        cur_we         = 1'b0;
        cur_av         = 1'b0;
        @(negedge clk);
    endtask

    // Monitor: every out-of-reset edge presents one registered write decision.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (running && !reset) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL scoreboard_underflow: got rf_we=%0b, expected no edge (t=%0t)", bus.rf_we, $time);
            end else begin
                e = exp_q.pop_front();
                check("rf_we", 32'(bus.rf_we), 32'(e.we));
                if (e.we) begin
                    check("rf_rd",    32'(bus.rf_rd), 32'(e.rd));
                    check("rf_wdata", bus.rf_wdata,   e.data);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no end of test, expected finish within time budget");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        int p_we;
        n_tests = 0; n_fail = 0; running = 1'b0;
        cur_we = 1'b0; cur_rd = '0; cur_wd = '0;
        cur_av = 1'b0; cur_ard = '0; cur_awd = '0;
        last_stall = 1'b0; last_aux_taken = 1'b0;
        m_wins = 0;
        bus.pipe_we = 1'b0; bus.pipe_rd = '0; bus.pipe_wdata = '0;
        bus.aux_valid = 1'b0; bus.aux_rd = '0; bus.aux_wdata = '0;
        reset = 1'b0;
        #1 reset = 1'b1;
        #2;
        check("init_rf_we",     32'(bus.rf_we),     32'd0);
        check("init_aux_ready", 32'(bus.aux_ready), 32'd0);
        check("init_aux_count", 32'(bus.aux_count), 32'd0);
        repeat (2) @(negedge clk);
        running = 1'b1;

        // Single aux result into an idle port
        repeat (3) drive();
        cur_av = 1'b1; cur_ard = 5'd5; cur_awd = 32'hA5A5_A5A5;
        drive();
        cur_av = 1'b0;
        repeat (4) drive();

        // Pipeline every cycle, one aux entry: forced grant after the starvation limit
        reset_check();
        cur_we = 1'b1; cur_rd = 5'd3; cur_wd = 32'h11;
        cur_av = 1'b1; cur_ard = 5'd7; cur_awd = 32'h77;
        drive();
        cur_av = 1'b0;
        repeat (10) drive();

        // Fill the FIFO under constant pipeline traffic; third entry waits for a pop
        reset_check();
        cur_we = 1'b1; cur_rd = 5'd4; cur_wd = 32'h44;
        k = 0;
        for (int i = 0; i < 20; i++) begin
            if (!cur_av || last_aux_taken) begin
                if (k < 3) begin
                    cur_av = 1'b1; cur_ard = 5'(9 + k); cur_awd = 32'(100 + k);
                    k++;
                end else begin
                    cur_av = 1'b0;
                end
            end
            drive();
        end

        // x0 destinations from both sources
        reset_check();
        cur_we = 1'b1; cur_rd = 5'd0; cur_wd = 32'hFFFF;
        repeat (3) drive();
        cur_we = 1'b0;
        cur_av = 1'b1; cur_ard = 5'd0; cur_awd = 32'h1234;
        drive();
        cur_av = 1'b0;
        repeat (3) drive();

        // Full FIFO, then reset mid-stream; no stale write afterwards
        reset_check();
        cur_we = 1'b1; cur_rd = 5'd6; cur_wd = 32'h66;
        cur_av = 1'b1; cur_ard = 5'd12; cur_awd = 32'hC0;
        drive();
        cur_ard = 5'd13; cur_awd = 32'hC1;
        drive();
        reset_check();
        repeat (4) drive();

        // Randomized traffic honouring stall/ready back-pressure
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) reset_check();
            p_we = (i < 1000) ? 90 : (i < 2000) ? 50 : 20;
            if (!(cur_we && last_stall)) begin
                cur_we = ($urandom_range(0, 99) < p_we);
                cur_rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom());
                cur_wd = $urandom();
            end
            if (!cur_av || last_aux_taken) begin
                cur_av  = ($urandom_range(0, 99) < 40);
                cur_ard = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom());
                cur_awd = $urandom();
            end
            drive();
        end

        @(posedge clk);
        #3;
        running = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
